hazard_ctrl: RTL and testbench

- Pipeline hazard controller. It consumes the execute-side outputs of the decode/execute pipeline register and drives control back toward the front end.
- It detects load-use hazards against the instruction currently in decode and stalls PC and IF/ID.
- It injects bubbles into the decode/execute register, and on jal/jalr/taken-branch resolution in execute it redirects the PC and flushes the wrong-path instructions.
- It keeps saturating stall and flush event counters for performance debug.

---
 rtl/aurora_pkg.sv | 6 +
 rtl/hazard_ctrl_if.sv | 22 ++
 rtl/sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 49 ++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/aurora_pkg.sv
// aurora_pkg: shared widths and FSM state type for the hazard controller
package aurora_pkg;
  localparam int PC_W = 8;
  localparam int REG_IDX_W = 5;
  typedef enum logic {RUN, LOAD_STALL} hz_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/execute sideband in, front-end control and perf counters out
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import aurora_pkg::*;
  logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_WReg1;
  logic id_use_rs1, id_use_rs2, ex_WRegEn, ex_mem_to_reg;
  logic ex_jal, ex_jalr, ex_br, ex_br_taken, cnt_clr;
  logic [PC_W-1:0] ex_target, pc_target;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_redirect, busy;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_WRegEn, ex_mem_to_reg, ex_WReg1,
           ex_jal, ex_jalr, ex_br, ex_br_taken, ex_target, cnt_clr,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_redirect, pc_target, busy,
           stall_count, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_WRegEn, ex_mem_to_reg, ex_WReg1,
           ex_jal, ex_jalr, ex_br, ex_br_taken, ex_target, cnt_clr,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pc_redirect, pc_target, busy,
           stall_count, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones; clear beats increment
module sat_counter #(parameter int W = 16) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and control-transfer redirect/flush for the front end
module hazard_ctrl import aurora_pkg::*; #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST_N,
  hazard_ctrl_if.slave bus
);
  hz_state_t r_state;
  logic [3:0] r_remain;
  logic w_hazard, w_redirect, w_stall;
  logic [CNT_W-1:0] w_stall_count, w_flush_count;
  assign w_hazard = bus.ex_mem_to_reg && bus.ex_WRegEn && bus.ex_WReg1 != '0 &&
                    ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_WReg1) ||
                     (bus.id_use_rs2 && bus.id_rs2 == bus.ex_WReg1));
  assign w_redirect = bus.ex_jal || bus.ex_jalr || (bus.ex_br && bus.ex_br_taken);
  // the decode instruction is wrong-path on a redirect, so its stall is moot
  assign w_stall = !w_redirect && (r_state == LOAD_STALL || w_hazard);
  assign bus.pc_stall = w_stall;
  assign bus.ifid_stall = w_stall;
  assign bus.ifid_flush = w_redirect;
  assign bus.idex_bubble = w_stall || w_redirect;
  assign bus.pc_redirect = w_redirect;
  assign bus.pc_target = w_redirect ? bus.ex_target : '0;
  assign bus.busy = r_state == LOAD_STALL;
  assign bus.stall_count = w_stall_count;
  assign bus.flush_count = w_flush_count;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state <= RUN;
      r_remain <= '0;
    end else if (w_redirect) begin
      r_state <= RUN;
      r_remain <= '0;
    end else if (r_state == LOAD_STALL) begin
      r_remain <= r_remain - 4'd1;
      r_state <= r_remain == 4'd1 ? RUN : LOAD_STALL;
    end else if (w_hazard && STALL_CYCLES > 1) begin
      r_state <= LOAD_STALL;
      r_remain <= 4'(STALL_CYCLES - 1);
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .RST_N(RST_N), .clr(bus.cnt_clr), .inc(w_stall), .q(w_stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .RST_N(RST_N), .clr(bus.cnt_clr), .inc(w_redirect), .q(w_flush_count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two controllers (1-cycle and 3-cycle stall, 4-bit counters) on shared stimulus
module tb_hazard_ctrl;
  localparam int CMAX = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1, rs2, wreg;
  logic use1, use2, wen, m2r, jal, jalr, br, taken, clr;
  logic [7:0] target;
  int n_cmp = 0, n_fail = 0;
  int stall_len [2] = '{1, 3};
  int left [2], sc [2], fc [2];

  hazard_ctrl_if #(.CNT_W(4)) ifa ();
  hazard_ctrl_if #(.CNT_W(4)) ifb ();
  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(4)) u_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hz();
    return m2r && wen && wreg != 0 && ((use1 && rs1 == wreg) || (use2 && rs2 == wreg));
  endfunction
  function automatic bit rd();
    return jal || jalr || (br && taken);
  endfunction
  // a stall cycle is either a fresh hazard or one still owed from an earlier load
  function automatic bit stall_exp(input int d);
    return !rd() && (left[d] > 0 || hz());
  endfunction

  task automatic idle();
    rs1 = 0; rs2 = 0; wreg = 0; use1 = 0; use2 = 0; wen = 0; m2r = 0;
    jal = 0; jalr = 0; br = 0; taken = 0; clr = 0; target = 0;
  endtask
  task automatic load_use(input int r);
    idle(); m2r = 1; wen = 1; wreg = 5'(r); rs2 = 5'(r); use2 = 1;
  endtask

  task automatic apply();
    ifa.id_rs1 = rs1; ifb.id_rs1 = rs1; ifa.id_rs2 = rs2; ifb.id_rs2 = rs2;
    ifa.id_use_rs1 = use1; ifb.id_use_rs1 = use1; ifa.id_use_rs2 = use2; ifb.id_use_rs2 = use2;
    ifa.ex_WRegEn = wen; ifb.ex_WRegEn = wen; ifa.ex_mem_to_reg = m2r; ifb.ex_mem_to_reg = m2r;
    ifa.ex_WReg1 = wreg; ifb.ex_WReg1 = wreg; ifa.ex_jal = jal; ifb.ex_jal = jal;
    ifa.ex_jalr = jalr; ifb.ex_jalr = jalr; ifa.ex_br = br; ifb.ex_br = br;
    ifa.ex_br_taken = taken; ifb.ex_br_taken = taken; ifa.ex_target = target; ifb.ex_target = target;
    ifa.cnt_clr = clr; ifb.cnt_clr = clr;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin left[d] = 0; sc[d] = 0; fc[d] = 0; end
  endtask

  task automatic model_update();
    bit s, r;
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) begin
      s = stall_exp(d); r = rd();
      sc[d] = clr ? 0 : (sc[d] + int'(s) > CMAX ? CMAX : sc[d] + int'(s));
      fc[d] = clr ? 0 : (fc[d] + int'(r) > CMAX ? CMAX : fc[d] + int'(r));
      left[d] = r ? 0 : left[d] > 0 ? left[d] - 1 : hz() ? stall_len[d] - 1 : 0;
    end
  endtask

  task automatic cmp_dut(input int d, input logic ps, is, fl, bb, rdo, input logic [7:0] tg,
                         input logic bz, input logic [3:0] scv, fcv);
    bit s, r;
    s = stall_exp(d); r = rd();
    chk($sformatf("d%0d pc_stall", d), int'(ps), int'(s));
    chk($sformatf("d%0d ifid_stall", d), int'(is), int'(s));
    chk($sformatf("d%0d ifid_flush", d), int'(fl), int'(r));
    chk($sformatf("d%0d idex_bubble", d), int'(bb), int'(s || r));
    chk($sformatf("d%0d pc_redirect", d), int'(rdo), int'(r));
    chk($sformatf("d%0d pc_target", d), int'(tg), r ? int'(target) : 0);
    chk($sformatf("d%0d busy", d), int'(bz), int'(left[d] > 0));
    chk($sformatf("d%0d stall_count", d), int'(scv), sc[d]);
    chk($sformatf("d%0d flush_count", d), int'(fcv), fc[d]);
  endtask

  task automatic compare();
    cmp_dut(0, ifa.pc_stall, ifa.ifid_stall, ifa.ifid_flush, ifa.idex_bubble, ifa.pc_redirect,
            ifa.pc_target, ifa.busy, ifa.stall_count, ifa.flush_count);
    cmp_dut(1, ifb.pc_stall, ifb.ifid_stall, ifb.ifid_flush, ifb.idex_bubble, ifb.pc_redirect,
            ifb.pc_target, ifb.busy, ifb.stall_count, ifb.flush_count);
  endtask

  task automatic step();
    apply();
    if (!rst_n) model_reset();
    #1 compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_step();
    idle(); clr = 1; step(); clr = 0;
  endtask

  initial begin
    idle(); model_reset();
    #2;
    step(); step();
    chk("reset a busy", int'(ifa.busy), 0);
    chk("reset b stall_count", int'(ifb.stall_count), 0);
    rst_n = 1;
    // single-cycle hazard: a stalls once, b owes two more
    load_use(5); apply(); #1;
    chk("t1 a pc_stall", int'(ifa.pc_stall), 1);
    chk("t1 b idex_bubble", int'(ifb.idex_bubble), 1);
    step();
    idle(); apply(); #1;
    chk("t1 a pc_stall after", int'(ifa.pc_stall), 0);
    chk("t1 b busy", int'(ifb.busy), 1);
    step(); step(); step();
    chk("t1 a stall_count", int'(ifa.stall_count), 1);
    chk("t1 b stall_count", int'(ifb.stall_count), 3);
    // hazard held for three cycles
    clear_step();
    load_use(9);
    step(); chk("t2 b busy c2", int'(ifb.busy), 1);
    step(); chk("t2 b busy c3", int'(ifb.busy), 1);
    step(); chk("t2 b busy end", int'(ifb.busy), 0);
    idle(); step();
    chk("t2 b stall_count", int'(ifb.stall_count), 3);
    chk("t2 a stall_count", int'(ifa.stall_count), 3);
    // no false hazards
    load_use(0); rs1 = 0; use1 = 1; apply(); #1;
    chk("x0 load", int'(ifa.pc_stall), 0); step();
    load_use(7); m2r = 0; rs1 = 7; use1 = 1; apply(); #1;
    chk("alu write", int'(ifa.pc_stall), 0); step();
    load_use(7); use2 = 0; rs1 = 7; use1 = 0; apply(); #1;
    chk("rs1 unused", int'(ifb.pc_stall), 0); step();
    // taken / not-taken branch
    clear_step();
    idle(); br = 1; taken = 1; target = 8'h3C; apply(); #1;
    chk("br redirect", int'(ifa.pc_redirect), 1);
    chk("br target", int'(ifa.pc_target), 'h3C);
    chk("br flush", int'(ifa.ifid_flush), 1);
    chk("br bubble", int'(ifa.idex_bubble), 1);
    step();
    taken = 0; apply(); #1;
    chk("nt redirect", int'(ifa.pc_redirect), 0);
    chk("nt target", int'(ifa.pc_target), 0);
    step();
    chk("br flush_count", int'(ifa.flush_count), 1);
    // jalr with simultaneous load-use
    clear_step();
    load_use(3); jalr = 1; target = 8'h80; apply(); #1;
    chk("sim redirect", int'(ifa.pc_redirect), 1);
    chk("sim target", int'(ifa.pc_target), 'h80);
    chk("sim pc_stall", int'(ifa.pc_stall), 0);
    step(); idle(); step();
    chk("sim stall_count", int'(ifa.stall_count), 0);
    // redirect arriving during a multi-cycle stall
    load_use(4); step();
    chk("ls busy", int'(ifb.busy), 1);
    idle(); jal = 1; target = 8'h55; apply(); #1;
    chk("ls redirect pc_stall", int'(ifb.pc_stall), 0);
    chk("ls redirect", int'(ifb.pc_redirect), 1);
    step();
    chk("ls back to run", int'(ifb.busy), 0);
    idle(); step();
    // reset asserted mid-stall
    load_use(6); step();
    rst_n = 0; #1;
    chk("rst busy", int'(ifb.busy), 0);
    chk("rst stall_count", int'(ifb.stall_count), 0);
    chk("rst flush_count", int'(ifa.flush_count), 0);
    idle(); step(); step();
    rst_n = 1; step();
    // saturation and clear-beats-increment
    load_use(8);
    for (int i = 0; i < 20; i++) step();
    chk("sat stall_count", int'(ifa.stall_count), 15);
    clr = 1; step(); clr = 0;
    chk("clr vs inc", int'(ifa.stall_count), 0);
    idle(); step(); step();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom % 150) != 0;
      wen = ($urandom % 4) != 0; m2r = 1'($urandom); wreg = 5'($urandom % 4);
      rs1 = 5'($urandom % 4); rs2 = 5'($urandom % 4); use1 = 1'($urandom); use2 = 1'($urandom);
      jal = ($urandom % 16) == 0; jalr = ($urandom % 16) == 0; br = ($urandom % 4) == 0;
      taken = 1'($urandom); target = 8'($urandom); clr = ($urandom % 40) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
